mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the unified memory's single data port among NUM_REQ requesters: core load/store unit, debug/program loader, DMA.
- Per requester: valid/ready request handshake and a one-cycle-latency response pulse. Memory side: synchronous-read, byte-strobed write.
- Out-of-range addresses are rejected with an error response and never reach memory.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_port_arbiter_rr_arbiter.sv | 22 ++
 rtl/mem_port_arbiter.sv | 64 ++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared memory-port types, limits and address check
package mem_port_arbiter_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic enable_t;
  localparam int unsigned MEM_BYTES = 65536;
  typedef enum logic [1:0] {RSP_READ, RSP_WRITE, RSP_ERR} rsp_kind_e;
  typedef struct packed {
    addr_t       addr;
    logic        we;
    logic [3:0]  wstrb;
    data_t       wdata;
  } mem_req_t;
  function automatic logic addr_ok(input addr_t a);
    return (a < addr_t'(MEM_BYTES)) && (a[1:0] == 2'b00);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side request/response bundle
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  addr_t [NUM_REQ-1:0]      req_addr;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ-1:0][3:0]  req_wstrb;
  data_t [NUM_REQ-1:0]      req_wdata;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic                     rsp_err;
  data_t                    rsp_rdata;
  modport slave (
    input  req_valid, req_addr, req_we, req_wstrb, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport master (
    output req_valid, req_addr, req_we, req_wstrb, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] k;
  // scan farthest-first so the nearest valid requester after ptr wins
  always_comb begin
    gnt_idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) gnt_idx = k;
    end
    gnt = |req ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one sync-read memory port with
// one-cycle responses and out-of-range/misaligned address rejection
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output addr_t                mem_addr_o,
  output enable_t              mem_ren_o,
  output enable_t              mem_wen_o,
  output logic [3:0]           mem_wstrb_o,
  output data_t                mem_wdata_o,
  input  data_t                mem_rdata_i
);
  logic [IDX_W-1:0]   r_ptr, r_owner, w_idx, w_nxt;
  logic               r_pend, w_acc;
  rsp_kind_e          r_kind, w_kind;
  logic [NUM_REQ-1:0] w_gnt;
  mem_req_t           w_req;

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_arb (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_idx)
  );

  always_comb begin
    w_req = '{addr: bus.req_addr[w_idx], we: bus.req_we[w_idx],
              wstrb: bus.req_wstrb[w_idx], wdata: bus.req_wdata[w_idx]};
    w_acc = rst_n && |bus.req_valid;
    w_kind = !addr_ok(w_req.addr) ? RSP_ERR : w_req.we ? RSP_WRITE : RSP_READ;
    w_nxt = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
    bus.req_ready = w_acc ? w_gnt : '0;
    mem_ren_o = w_acc && w_kind == RSP_READ;
    mem_wen_o = w_acc && w_kind == RSP_WRITE;
    mem_addr_o = (mem_ren_o || mem_wen_o) ? w_req.addr : '0;
    mem_wstrb_o = mem_wen_o ? w_req.wstrb : '0;
    mem_wdata_o = mem_wen_o ? w_req.wdata : '0;
    bus.rsp_valid = r_pend ? NUM_REQ'(1) << r_owner : '0;
    bus.rsp_err = r_pend && r_kind == RSP_ERR;
    bus.rsp_rdata = (r_pend && r_kind == RSP_READ) ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_pend  <= 1'b0;
      r_owner <= '0;
      r_kind  <= RSP_READ;
    end else begin
      r_pend <= w_acc;
      if (w_acc) begin
        r_ptr   <= w_nxt;
        r_owner <= w_idx;
        r_kind  <= w_kind;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus contention/reset/fairness sequences,
// responses checked against a queue of expectations pushed at accept time
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    int          r;
    addr_t       addr;
    logic        we;
    logic [3:0]  strb;
    data_t       wdata;
    logic        ren;
    logic        wen;
    logic        err;
    data_t       rdata;
  } vec_t;

  typedef struct {
    logic [2:0] vld;
    logic       err;
    data_t      rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  addr_t      mem_addr_o;
  enable_t    mem_ren_o, mem_wen_o;
  logic [3:0] mem_wstrb_o;
  data_t      mem_wdata_o, mem_rdata;
  data_t      mem [16384];
  exp_t       q[$];
  vec_t       tbl[11];
  int         tests = 0, fails = 0;
  int         rsp_cnt[3];

  mem_port_arbiter_if #(.NUM_REQ(3)) bus();

  mem_port_arbiter #(.NUM_REQ(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_addr_o  (mem_addr_o),
    .mem_ren_o   (mem_ren_o),
    .mem_wen_o   (mem_wen_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen_o)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb_o[b]) mem[mem_addr_o[15:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
    if (mem_ren_o) mem_rdata <= mem[mem_addr_o[15:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    chk("rsp_onehot", 32'($onehot0(bus.rsp_valid)), 32'd1);
    for (int i = 0; i < 3; i++) if (bus.rsp_valid[i] === 1'b1) rsp_cnt[i]++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.vld));
      chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      chk("rsp_rdata", bus.rsp_rdata, e.rdata);
    end else begin
      chk("rsp_idle", 32'({bus.rsp_err, bus.rsp_valid}), 32'd0);
      chk("rsp_idle_rdata", bus.rsp_rdata, 32'd0);
    end
  endtask

  task automatic push(input int r, input logic err, input data_t rd);
    exp_t e;
    e.vld = 3'(1 << r);
    e.err = err;
    e.rdata = rd;
    q.push_back(e);
  endtask

  task automatic drive(input int r, input addr_t a, input logic we, input logic [3:0] s, input data_t d);
    bus.req_addr[r] = a;
    bus.req_we[r] = we;
    bus.req_wstrb[r] = s;
    bus.req_wdata[r] = d;
  endtask

  task automatic idle_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    check_rsp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v1, w1, prev, gi;
    logic [2:0] g;
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE0000 | i;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'hAAAAAAAA;
    tbl[0]  = '{0, 32'h0000_0010, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[1]  = '{1, 32'h0000_0020, 1'b1, 4'h3, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1, 32'h0000_0020, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hAAAA5678};
    tbl[3]  = '{2, 32'h0001_0000, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    tbl[4]  = '{2, 32'h0000_0006, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    tbl[5]  = '{0, 32'h0000_0010, 1'b1, 4'h8, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{0, 32'h0000_0010, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h11ADBEEF};
    tbl[7]  = '{2, 32'h0000_FFFC, 1'b1, 4'hF, 32'h55555555, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1, 32'h0000_FFFC, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h55555555};
    tbl[9]  = '{1, 32'h0000_FFFE, 1'b1, 4'hF, 32'h99999999, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[10] = '{0, 32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    for (int r = 0; r < 3; r++) drive(r, 32'h0, 1'b0, 4'h0, 32'h0);
    rst_n = 1'b0;
    bus.req_valid = 3'b111;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_mem_en", 32'({mem_ren_o, mem_wen_o}), 32'd0);
    chk("reset_rsp", 32'({bus.rsp_err, bus.rsp_valid}), 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_mem_addr", mem_addr_o, 32'd0);
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].addr, tbl[n].we, tbl[n].strb, tbl[n].wdata);
      bus.req_valid = 3'(1 << tbl[n].r);
      @(negedge clk);
      check_rsp();
      chk("vec_ready", 32'(bus.req_ready), 32'(1 << tbl[n].r));
      chk("vec_ren", 32'(mem_ren_o), 32'(tbl[n].ren));
      chk("vec_wen", 32'(mem_wen_o), 32'(tbl[n].wen));
      chk("vec_mem_addr", mem_addr_o, (tbl[n].ren || tbl[n].wen) ? tbl[n].addr : 32'h0);
      if (tbl[n].wen) begin
        chk("vec_wstrb", 32'(mem_wstrb_o), 32'(tbl[n].strb));
        chk("vec_wdata", mem_wdata_o, tbl[n].wdata);
      end
      push(tbl[n].r, tbl[n].err, tbl[n].rdata);
      @(posedge clk);
      #1;
    end
    idle_cycle();

    // read from req1 then reset before its response edge: response must vanish
    drive(1, 32'h10, 1'b0, 4'h0, 32'h0);
    bus.req_valid = 3'b010;
    @(negedge clk);
    check_rsp();
    chk("midrst_ready", 32'(bus.req_ready), 32'b010);
    chk("midrst_ren", 32'(mem_ren_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready0", 32'(bus.req_ready), 32'd0);
    chk("midrst_ren0", 32'(mem_ren_o), 32'd0);
    chk("midrst_rsp0", 32'({bus.rsp_err, bus.rsp_valid}), 32'd0);
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r < 3; r++) begin
      drive(r, 32'h100 + 4 * r, 1'b0, 4'h0, 32'h0);
      rsp_cnt[r] = 0;
    end
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_rsp();
      chk("cont_ready", 32'(bus.req_ready), 32'(1 << (k % 3)));
      chk("cont_ren", 32'(mem_ren_o), 32'd1);
      chk("cont_addr", mem_addr_o, 32'h100 + 4 * (k % 3));
      push(k % 3, 1'b0, 32'hC0DE0040 + (k % 3));
      @(posedge clk);
      #1;
    end
    idle_cycle();
    for (int r = 0; r < 3; r++) chk("cont_rsp_count", 32'(rsp_cnt[r]), 32'd2);

    for (int r = 0; r < 3; r++) drive(r, 32'h200 + 4 * r, 1'b0, 4'h0, 32'h0);
    v1 = 1;
    w1 = 0;
    prev = 2;
    for (int k = 0; k < 12; k++) begin
      bus.req_valid = {1'b1, v1[0], 1'b1};
      @(negedge clk);
      check_rsp();
      g = bus.req_ready;
      gi = -1;
      for (int i = 0; i < 3; i++) if (g[i] === 1'b1) gi = i;
      chk("fair_onehot", 32'($onehot(g)), 32'd1);
      chk("fair_no_repeat", 32'(gi != prev), 32'd1);
      if (gi >= 0) push(gi, 1'b0, 32'hC0DE0080 + gi);
      if (v1 == 1) begin
        w1++;
        if (gi == 1) begin
          chk("fair_req1_latency", 32'(w1 <= 2), 32'd1);
          v1 = 0;
          w1 = 0;
        end
      end else begin
        chk("fair_no_gnt_idle", 32'(gi != 1), 32'd1);
        v1 = 1;
      end
      prev = gi;
      @(posedge clk);
      #1;
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
